// File: rtl/parking_slot_table.sv
// rtl/parking_slot_table.sv - parking bay occupancy, entry-time and exit-cost record store
// Allocates the lowest free bay on entry, prices a stay on exit with wrap-safe duration and saturation.
module parking_slot_table #(
  parameter int NUM_SLOTS = 8,
  parameter int TIME_W    = 10,
  parameter int COST_W    = 10,
  parameter int RATE      = 2,
  parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              entry_req,
  input  logic [TIME_W-1:0] entry_time_in,
  output logic              entry_ack,
  output logic              entry_rej,
  output logic [SLOT_W-1:0] entry_slot,
  input  logic              exit_req,
  input  logic [SLOT_W-1:0] exit_slot,
  input  logic [TIME_W-1:0] exit_time_in,
  output logic              exit_done,
  output logic              exit_err,
  output logic [COST_W-1:0] exit_cost,
  input  logic [SLOT_W-1:0] rd_slot,
  output logic              rd_occupied,
  output logic [TIME_W-1:0] rd_entry_time,
  output logic [COST_W-1:0] rd_cost,
  output logic [SLOT_W:0]   occ_count,
  output logic              full,
  output logic              empty
);

  // Storage is padded to the full index range; bays >= NUM_SLOTS are never
  // written, so they read as empty and any exit to them is refused.
  localparam int DEPTH = 1 << SLOT_W;
  localparam logic [63:0] MAX_COST = (64'd1 << COST_W) - 64'd1;
  localparam logic [SLOT_W:0] CNT_ONE = (SLOT_W+1)'(1);

  logic [DEPTH-1:0]  occ_q, occ_d;
  logic [TIME_W-1:0] entry_time_q [DEPTH];
  logic [TIME_W-1:0] entry_time_d [DEPTH];
  logic [COST_W-1:0] cost_q [DEPTH];
  logic [COST_W-1:0] cost_d [DEPTH];
  logic [SLOT_W:0]   occ_count_q, occ_count_d;
  logic              entry_ack_q, entry_ack_d;
  logic              entry_rej_q, entry_rej_d;
  logic [SLOT_W-1:0] entry_slot_q, entry_slot_d;
  logic              exit_done_q, exit_done_d;
  logic              exit_err_q, exit_err_d;
  logic [COST_W-1:0] exit_cost_q, exit_cost_d;

  logic [SLOT_W-1:0] free_idx;
  logic [TIME_W-1:0] dur;
  logic [63:0]       prod;
  logic [COST_W-1:0] sat_cost;

  always_comb begin
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occ_q[i]) free_idx = SLOT_W'(i);
    end
  end

  // Modular subtraction gives the correct stay length across a clock wrap.
  assign dur      = exit_time_in - entry_time_q[exit_slot];
  assign prod     = 64'(dur) * 64'(RATE);
  assign sat_cost = (prod > MAX_COST) ? {COST_W{1'b1}} : prod[COST_W-1:0];

  always_comb begin
    occ_d        = occ_q;
    entry_time_d = entry_time_q;
    cost_d       = cost_q;
    occ_count_d  = occ_count_q;
    entry_ack_d  = 1'b0;
    entry_rej_d  = 1'b0;
    entry_slot_d = entry_slot_q;
    exit_done_d  = 1'b0;
    exit_err_d   = 1'b0;
    exit_cost_d  = exit_cost_q;

    if (exit_req) begin
      if (occ_q[exit_slot]) begin
        occ_d[exit_slot]  = 1'b0;
        cost_d[exit_slot] = sat_cost;
        exit_cost_d       = sat_cost;
        exit_done_d       = 1'b1;
        occ_count_d       = occ_count_d - CNT_ONE;
      end else begin
        exit_err_d = 1'b1;
      end
    end

    // Allocation looks at pre-edge occupancy, so a bay freed above is never reused this cycle.
    if (entry_req) begin
      if (full) begin
        entry_rej_d = 1'b1;
      end else begin
        occ_d[free_idx]        = 1'b1;
        entry_time_d[free_idx] = entry_time_in;
        entry_ack_d            = 1'b1;
        entry_slot_d           = free_idx;
        occ_count_d            = occ_count_d + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q        <= '0;
      entry_time_q <= '{default: '0};
      cost_q       <= '{default: '0};
      occ_count_q  <= '0;
      entry_ack_q  <= 1'b0;
      entry_rej_q  <= 1'b0;
      entry_slot_q <= '0;
      exit_done_q  <= 1'b0;
      exit_err_q   <= 1'b0;
      exit_cost_q  <= '0;
    end else begin
      occ_q        <= occ_d;
      entry_time_q <= entry_time_d;
      cost_q       <= cost_d;
      occ_count_q  <= occ_count_d;
      entry_ack_q  <= entry_ack_d;
      entry_rej_q  <= entry_rej_d;
      entry_slot_q <= entry_slot_d;
      exit_done_q  <= exit_done_d;
      exit_err_q   <= exit_err_d;
      exit_cost_q  <= exit_cost_d;
    end
  end

  assign entry_ack     = entry_ack_q;
  assign entry_rej     = entry_rej_q;
  assign entry_slot    = entry_slot_q;
  assign exit_done     = exit_done_q;
  assign exit_err      = exit_err_q;
  assign exit_cost     = exit_cost_q;
  assign occ_count     = occ_count_q;
  assign full          = (occ_count_q == (SLOT_W+1)'(NUM_SLOTS));
  assign empty         = (occ_count_q == '0);
  assign rd_occupied   = occ_q[rd_slot];
  assign rd_entry_time = entry_time_q[rd_slot];
  assign rd_cost       = cost_q[rd_slot];

endmodule
